dm_resp: RTL and testbench

DM_RESP -- requirements
Module: dm_resp

---
 rtl/dm_resp.sv | 186 ++++++++++++++++++
 tb/tb_dm_resp.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_resp.sv
// -----------------------------------------------------------------------------
// dm_resp -- single-outstanding memory responder with fixed wait states.
//
// Accepts one request at a time through a valid/ready handshake. It then waits
// WAIT_CYC cycles and presents a response that is held until the initiator
// takes it. Storage is 1024 x 32-bit words with byte-enable writes.
//
// Parameters
//   WAIT_CYC   memory wait states per access (0..15)
//
// Ports
//   clk        clock, all state changes on rising edge
//   rst        asynchronous active-low reset
//   req_valid  initiator presents a request
//   req_ready  responder can accept (high only when idle)
//   req_we     1 = write, 0 = read
//   req_addr   byte address, word index = req_addr[11:2]
//   req_wdata  write data
//   req_be     byte enables, bit i covers bits [8i+7:8i]
//   resp_valid response presented (held until resp_ready)
//   resp_ready initiator accepts the response
//   resp_rdata read data (post-write word on writes, 0 on error)
//   resp_err   request was misaligned or outside the 4 KiB window
//   busy       high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module dm_resp #(
   parameter int WAIT_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   // Storage: no reset, so contents survive rst.
   logic [31:0] mem [0:1023];

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        lat_we_reg;
   logic [9:0]  lat_idx_reg;
   logic [31:0] lat_wdata_reg;
   logic [3:0]  lat_be_reg;
   logic        lat_err_reg;
   logic        req_ready_reg;
   logic        resp_valid_reg;
   logic [31:0] resp_rdata_reg;
   logic        resp_err_reg;
   logic        busy_reg;

   logic        accept;
   logic        enter_resp;
   logic        in_err;
   logic        cur_we;
   logic        cur_err;
   logic [9:0]  cur_idx;
   logic [31:0] cur_wdata;
   logic [3:0]  cur_be;
   logic [31:0] old_word;
   logic [31:0] merged_word;
   logic        mem_we;

   assign in_err     = (req_addr[1:0] != 2'b00) || (req_addr[31:12] != 20'd0);
   assign accept     = req_valid && req_ready_reg;
   assign enter_resp = ((state_reg == IDLE) && accept && (WAIT_CYC == 0)) ||
                       ((state_reg == WAIT) && (cnt_reg == 4'd0));

   // With zero wait states RESP is entered on the accept edge itself, before
   // the request has been latched, so the live inputs are used in that case.
   always_comb begin
      cur_we    = lat_we_reg;
      cur_err   = lat_err_reg;
      cur_idx   = lat_idx_reg;
      cur_wdata = lat_wdata_reg;
      cur_be    = lat_be_reg;
      if (state_reg == IDLE) begin
         cur_we    = req_we;
         cur_err   = in_err;
         cur_idx   = req_addr[11:2];
         cur_wdata = req_wdata;
         cur_be    = req_be;
      end
   end

   assign old_word = mem[cur_idx];

   for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign merged_word[8*gi +: 8] = cur_be[gi] ? cur_wdata[8*gi +: 8] : old_word[8*gi +: 8];
   end

   // Commit happens only on the edge entering RESP; a reset during WAIT moves
   // the FSM back to IDLE before that edge, so the write is dropped.
   assign mem_we = enter_resp && cur_we && !cur_err;

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[cur_idx] <= merged_word;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= 4'd0;
         lat_we_reg     <= 1'b0;
         lat_idx_reg    <= 10'd0;
         lat_wdata_reg  <= 32'd0;
         lat_be_reg     <= 4'd0;
         lat_err_reg    <= 1'b0;
         req_ready_reg  <= 1'b1;
         resp_valid_reg <= 1'b0;
         resp_rdata_reg <= 32'd0;
         resp_err_reg   <= 1'b0;
         busy_reg       <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  lat_we_reg    <= req_we;
                  lat_idx_reg   <= req_addr[11:2];
                  lat_wdata_reg <= req_wdata;
                  lat_be_reg    <= req_be;
                  lat_err_reg   <= in_err;
                  req_ready_reg <= 1'b0;
                  busy_reg      <= 1'b1;
                  state_reg     <= WAIT;
                  cnt_reg       <= CNT_LOAD;
               end
            end
            WAIT: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  state_reg      <= IDLE;
                  req_ready_reg  <= 1'b1;
                  busy_reg       <= 1'b0;
                  resp_valid_reg <= 1'b0;
                  resp_rdata_reg <= 32'd0;
                  resp_err_reg   <= 1'b0;
               end
            end
            default: begin
               state_reg     <= IDLE;
               req_ready_reg <= 1'b1;
               busy_reg      <= 1'b0;
            end
         endcase

         // Overrides the IDLE->WAIT move when there are no wait states.
         if (enter_resp) begin
            state_reg      <= RESP;
            cnt_reg        <= 4'd0;
            resp_valid_reg <= 1'b1;
            resp_err_reg   <= cur_err;
            resp_rdata_reg <= cur_err ? 32'd0 : (cur_we ? merged_word : old_word);
         end
      end
   end

   assign req_ready  = req_ready_reg;
   assign resp_valid = resp_valid_reg;
   assign resp_rdata = resp_rdata_reg;
   assign resp_err   = resp_err_reg;
   assign busy       = busy_reg;

endmodule

// File: tb/tb_dm_resp.sv
// -----------------------------------------------------------------------------
// tb_dm_resp -- directed, table-driven bench for dm_resp.
// One instance with WAIT_CYC=2 carries the vector table and the backpressure
// and reset sequences; a second with WAIT_CYC=0 checks back-to-back reads.
// -----------------------------------------------------------------------------
module tb_dm_resp;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [3:0]  req_be = 4'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   logic        z_req_valid = 1'b0;
   logic        z_req_ready;
   logic        z_req_we = 1'b0;
   logic [31:0] z_req_addr = 32'd0;
   logic [31:0] z_req_wdata = 32'd0;
   logic [3:0]  z_req_be = 4'd0;
   logic        z_resp_valid;
   logic        z_resp_ready = 1'b1;
   logic [31:0] z_resp_rdata;
   logic        z_resp_err;
   logic        z_busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dm_resp #(.WAIT_CYC(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
   );

   dm_resp #(.WAIT_CYC(0)) dut0 (
      .clk(clk), .rst(rst),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
      .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
      .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   // Waits (bounded) until req_ready is seen at a falling edge.
   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk1({name, "_ready"}, req_ready, 1'b1);
   endtask

   // Waits (bounded) for resp_valid; returns number of falling edges seen.
   task automatic wait_resp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (resp_valid !== 1'b1 && n < 50);
   endtask

   // Full transaction on the WAIT_CYC=2 instance with resp_ready held high.
   task automatic txn(input string name, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [31:0] exp_rd, input logic exp_err);
      int n;
      logic [31:0] rd;
      logic er;
      @(negedge clk);
      req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      req_valid = 1'b1; resp_ready = 1'b1;
      wait_ready(name);
      @(posedge clk);
      #1;
      // Scramble inputs after accept: the access must use the latched values.
      req_valid = 1'b0; req_we = ~we; req_addr = addr ^ 32'h4;
      req_wdata = ~wdata; req_be = ~be;
      wait_resp(n);
      chk({name, "_latency"}, n, W + 1);
      rd = resp_rdata;
      er = resp_err;
      chk({name, "_rdata"}, rd, exp_rd);
      chk1({name, "_err"}, er, exp_err);
      @(negedge clk);
      chk1({name, "_valid_drop"}, resp_valid, 1'b0);
      chk({name, "_rdata_idle"}, resp_rdata, 32'd0);
      chk1({name, "_ready_back"}, req_ready, 1'b1);
      $display("TXN %s we=%0b addr=%08h wdata=%08h be=%04b -> rdata=%08h err=%0b lat=%0d",
               name, we, addr, wdata, be, rd, er, n);
   endtask

   initial begin
      int n;
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 1'b0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, 32'hDE22_BE44, 1'b0};
      vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b0000, 32'hDE22_BE44, 1'b0};
      vecs[4]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b0};
      vecs[5]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h0000_0000, 1'b1};
      vecs[6]  = '{1'b0, 32'h0000_1002, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1};
      vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'b1111, 32'h0000_0000, 1'b1};
      vecs[8]  = '{1'b1, 32'h0000_0012, 32'hFFFF_FFFF, 4'b1111, 32'h0000_0000, 1'b1};
      vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b1111, 32'hCAFE_F00D, 1'b0};
      vecs[10] = '{1'b1, 32'h0000_0FFC, 32'h0102_0304, 4'b1111, 32'h0102_0304, 1'b0};
      vecs[11] = '{1'b1, 32'h0000_0FFC, 32'hFFFF_FFFF, 4'b0000, 32'h0102_0304, 1'b0};
      vecs[12] = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 4'b1111, 32'h0102_0304, 1'b0};
      vecs[13] = '{1'b1, 32'h0000_0020, 32'hAAAA_AAAA, 4'b1111, 32'hAAAA_AAAA, 1'b0};
      vecs[14] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 32'hDE22_BE44, 1'b0};

      // Reset takes effect without a clock edge.
      #1 rst = 1'b0;
      #1;
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk1("rst_err", resp_err, 1'b0);
      #20 rst = 1'b1;
      @(negedge clk);
      chk1("rst_req_ready", req_ready, 1'b1);
      $display("TXN reset released req_ready=%0b", req_ready);

      for (int i = 0; i < 15; i++) begin
         txn($sformatf("v%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].be, vecs[i].exp_rd, vecs[i].exp_err);
      end

      // Backpressure: response held for 5 cycles, new request ignored.
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF; req_valid = 1'b1; resp_ready = 1'b0;
      wait_ready("bp");
      @(posedge clk);
      #1;
      req_we = 1'b1; req_wdata = 32'h0; req_be = 4'hF;
      wait_resp(n);
      chk("bp_latency", n, W + 1);
      for (int k = 0; k < 5; k++) begin
         chk1($sformatf("bp_valid%0d", k), resp_valid, 1'b1);
         chk($sformatf("bp_rdata%0d", k), resp_rdata, 32'hDE22_BE44);
         chk1($sformatf("bp_req_ready%0d", k), req_ready, 1'b0);
         if (k < 4) @(negedge clk);
      end
      resp_ready = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      chk1("bp_release_valid", resp_valid, 1'b0);
      chk1("bp_release_ready", req_ready, 1'b1);
      chk1("bp_release_busy", busy, 1'b0);
      $display("TXN backpressure read 0x10 held 5 cycles released");
      txn("bp_check", 1'b0, 32'h10, 32'h0, 4'hF, 32'hDE22_BE44, 1'b0);

      // Reset mid-WAIT drops an uncommitted write.
      @(negedge clk);
      req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h5555_5555; req_be = 4'hF;
      req_valid = 1'b1; resp_ready = 1'b1;
      wait_ready("rw");
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk1("rw_busy_wait", busy, 1'b1);
      chk1("rw_valid_wait", resp_valid, 1'b0);
      #2 rst = 1'b0;
      #1;
      chk1("rw_busy_async", busy, 1'b0);
      chk1("rw_ready_async", req_ready, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      $display("TXN reset during WAIT of write 0x55555555 to 0x20");

      // Reset while a response is being held clears outputs at once.
      @(negedge clk);
      req_we = 1'b0; req_addr = 32'h10; req_valid = 1'b1; resp_ready = 1'b0;
      wait_ready("rr");
      @(posedge clk);
      #1 req_valid = 1'b0;
      wait_resp(n);
      chk("rr_rdata_before", resp_rdata, 32'hDE22_BE44);
      #2 rst = 1'b0;
      #1;
      chk1("rr_valid_async", resp_valid, 1'b0);
      chk("rr_rdata_async", resp_rdata, 32'd0);
      chk1("rr_err_async", resp_err, 1'b0);
      chk1("rr_busy_async", busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      resp_ready = 1'b1;
      $display("TXN reset during RESP of read 0x10");
      txn("rw_check", 1'b0, 32'h20, 32'h0, 4'hF, 32'hAAAA_AAAA, 1'b0);

      // WAIT_CYC=0: write then back-to-back reads with req_valid held high.
      @(negedge clk);
      z_req_we = 1'b1; z_req_addr = 32'h14; z_req_wdata = 32'h0BAD_F00D; z_req_be = 4'hF;
      z_req_valid = 1'b1; z_resp_ready = 1'b1;
      chk1("z_ready_first", z_req_ready, 1'b1);
      @(posedge clk);
      #1 z_req_we = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk1($sformatf("z_valid%0d", i), z_resp_valid, (i % 2) == 0);
         chk1($sformatf("z_ready%0d", i), z_req_ready, (i % 2) == 1);
         if ((i % 2) == 0) begin
            chk($sformatf("z_rdata%0d", i), z_resp_rdata, 32'h0BAD_F00D);
         end
         $display("TXN z cycle %0d valid=%0b ready=%0b rdata=%08h",
                  i, z_resp_valid, z_req_ready, z_resp_rdata);
      end
      z_req_valid = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
